mems_i2s_ctrl: RTL and testbench
================================

Name: mems_i2s_ctrl

Overview:
- I2S master controller for a stereo pair of MEMS microphones sharing one data line.
- Divides the system clock to produce SCK, and sequences the 64-slot WS frame: left half slots 0..31, right half slots 32..63.
- Deserialises the shared SD line and presents each completed sample on a 16-bit parallel bus, with a one-cycle left or right strobe.
- Sits between the mic pads and the downstream sample-processing logic.

Parameters:
- DIV, 4: clk cycles per SCK half-period; SCK period = 2*DIV clk cycles; legal range 2..255.
- WIDTH, 16: significant bits per sample captured, MSB first; legal range 1..16.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  run enable; low stops and parks the interface.
- sd  input  1  shared serial data from both mics.
- sck  output  1  I2S bit clock to the mics.
- ws  output  1  word select to the mics: 0 = left half, 1 = right half.
- bus  output  16  last completed sample, left-justified; unused low bits are 0.
- left  output  1  one-clk strobe: bus just updated with a left sample.
- right  output  1  one-clk strobe: bus just updated with a right sample.

Behaviour:
- Reset (async, rst_n low): sck=0, ws=0, bus=0, left=0, right=0; divider=0, slot=0, shift register=0.
- en low (sampled on clk): on the next edge sck=0, ws=0, divider=0, slot=0, shift=0, strobes=0.
  - bus holds its last value.
  - A partial sample in progress is discarded; no strobe is issued for it.
- en high: divider counts 0..DIV-1. At count DIV-1 the divider wraps to 0 and sck toggles.
- Rising-edge event: the clk edge at which sck goes 0->1.
  - sd is sampled on this same edge.
  - h = slot mod 32.
  - If 1 <= h <= WIDTH: shift <= {shift[WIDTH-2:0], sd}. This gives I2S one-bit delay after the WS change: MSB in h=1.
  - Values of sd in h=0 and h>WIDTH are ignored.
- Falling-edge event: the clk edge at which sck goes 1->0.
  - slot <= (slot+1) mod 64.
  - On the same edge, ws <= 1 if the new slot >= 32, else 0. WS therefore changes only coincident with SCK falling.
- Sample completion, on the rising-edge event in slot 31:
  - bus[15:16-WIDTH] <= shift, low bits 0.
  - left=1 for exactly one clk.
  - The same edge also completes the shift for h=31, which is a no-op.
- Sample completion, on the rising-edge event in slot 63: same update of bus, with right=1 for one clk.
- left and right are never high together. Each strobes once per frame (64*2*DIV clk cycles).
- Strobe latency: left rises on the same clk edge as sck rises in slot 31. That is 63*DIV clk edges after the first edge that samples en=1, counting from a parked state.
- Re-enable: always starts at slot 0 with a full SCK low phase of DIV clks.
- Reset asserted mid-frame: immediate return to reset values, including bus=0. After release, the block behaves as a fresh enable.
- The shift register is only WIDTH bits wide. Bits beyond WIDTH are never shifted, so the mic's trailing bits cannot corrupt the MSBs.

Test Plan:
- Reset: hold rst_n=0 with en=1 and sd toggling -> sck, ws, bus, left, right all 0 throughout. Release with en=1 -> first sck rise after 4 clks (DIV=4).
- Clock timing, DIV=4:
  - sck period is exactly 8 clk; ws period is exactly 512 clk.
  - ws changes only on edges where sck falls.
  - ws rises after slot 31's falling edge and falls after slot 63's.
- Data capture: mic model drives left 0xA5C3 and right 0x1234, MSB in h=1, per I2S.
  - left pulses 1 clk with bus=0xA5C3.
  - right pulses 256 clk later with bus=0x1234.
  - Result repeats every frame.
- Ignored bits: drive sd=1 in h=0 and h=17..31, with payload 0x0000 -> bus=0x0000 and strobes still occur. With WIDTH=12 and payload 0xABC -> bus=0xABC0.
- Enable abort: drop en mid-left-half (slot 10).
  - sck=0 and ws=0 next clk; no strobe occurs; bus retains the previous value.
  - Re-raise en -> left strobe exactly 252 clks later with correct new data.
- Async reset mid-frame: pulse rst_n low at slot 40, not aligned to clk.
  - Outputs go to 0 immediately, without waiting for a clk edge.
  - After release, the first left strobe occurs after 252 clks.

Source files
------------

// File: rtl/mems_i2s_ctrl.sv
// rtl/mems_i2s_ctrl.sv - I2S master for a stereo MEMS mic pair sharing one SD line
module mems_i2s_ctrl #(
  parameter int DIV   = 4,
  parameter int WIDTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        sd,
  output logic        sck,
  output logic        ws,
  output logic [15:0] bus,
  output logic        left,
  output logic        right
);

  localparam logic [7:0] div_last = 8'(DIV - 1);
  localparam logic [5:0] width_l  = 6'(WIDTH);

  logic [7:0]       div_cnt;
  logic [5:0]       slot;
  logic [5:0]       slot_inc;
  logic [5:0]       h;
  logic [WIDTH-1:0] shift;
  logic [WIDTH-1:0] shift_next;
  logic [15:0]      cap;
  logic             tick;
  logic             rise;
  logic             fall;
  logic             in_window;

  assign tick      = (div_cnt == div_last);
  assign rise      = tick && !sck;
  assign fall      = tick && sck;
  assign h         = {1'b0, slot[4:0]};
  // I2S one-bit delay: MSB arrives in h=1, bits past WIDTH never enter the register
  assign in_window = (h != 6'd0) && (h <= width_l);
  assign slot_inc  = slot + 6'd1;
  assign cap       = 16'(shift) << (16 - WIDTH);

  generate
    if (WIDTH > 1) begin : g_wide
      assign shift_next = {shift[WIDTH-2:0], sd};
    end else begin : g_narrow
      assign shift_next = sd;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      slot    <= '0;
      shift   <= '0;
      sck     <= 1'b0;
      ws      <= 1'b0;
      bus     <= '0;
      left    <= 1'b0;
      right   <= 1'b0;
    end else if (!en) begin
      // park: bus keeps the last completed sample, any partial sample is dropped
      div_cnt <= '0;
      slot    <= '0;
      shift   <= '0;
      sck     <= 1'b0;
      ws      <= 1'b0;
      left    <= 1'b0;
      right   <= 1'b0;
    end else begin
      left  <= 1'b0;
      right <= 1'b0;
      if (tick) begin
        div_cnt <= '0;
        sck     <= ~sck;
      end else begin
        div_cnt <= div_cnt + 8'd1;
      end
      if (rise) begin
        if (in_window) shift <= shift_next;
        if (slot == 6'd31) begin
          bus  <= cap;
          left <= 1'b1;
        end
        if (slot == 6'd63) begin
          bus   <= cap;
          right <= 1'b1;
        end
      end
      if (fall) begin
        slot <= slot_inc;
        ws   <= slot_inc[5];
      end
    end
  end

endmodule

// File: tb/tb_mems_i2s_ctrl.sv
// tb/tb_mems_i2s_ctrl.sv - scoreboard bench for mems_i2s_ctrl with a behavioural I2S mic pair
module tb_mems_i2s_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic sd_a = 1'b0;
  logic sd_b = 1'b0;

  logic        sck_a, ws_a, left_a, right_a;
  logic [15:0] bus_a;
  logic        sck_b, ws_b, left_b, right_b;
  logic [15:0] bus_b;

  mems_i2s_ctrl #(.DIV(4), .WIDTH(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .sd(sd_a),
    .sck(sck_a), .ws(ws_a), .bus(bus_a), .left(left_a), .right(right_a)
  );

  mems_i2s_ctrl #(.DIV(4), .WIDTH(12)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .sd(sd_b),
    .sck(sck_b), .ws(ws_b), .bus(bus_b), .left(left_b), .right(right_b)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int total = 0;
  int bad = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  typedef logic [16:0] exp_t;
  exp_t qa[$];
  exp_t qb[$];

  logic [15:0] pl_left = 16'hA5C3;
  logic [15:0] pl_right = 16'h1234;
  logic [11:0] pb_left = 12'hABC;
  logic [11:0] pb_right = 12'h5A5;
  logic        fill = 1'b0;

  int lat_seq = 0;
  int lat_cyc = 0;
  int rise_seq = 0;
  int rise_cyc = 0;

  int   tb_slot = 0;
  int   strobes = 0;
  logic sck_prev = 1'b0;
  logic ws_prev = 1'b0;
  int   lat_seen = 0;
  int   rise_seen = 0;
  int   last_rise = -1;
  int   last_ws_rise = -1;
  int   last_left = -1;

  // monitor, scoreboard and mic model all run on the falling clk edge
  always @(negedge clk) begin : mon
    exp_t e;
    int   hh;
    logic act;
    act = rst_n && en;

    if (left_a || right_a) begin
      check("a_both_strobes", {31'd0, left_a & right_a}, 32'd0);
      if (qa.size() == 0) begin
        total++;
        bad++;
        $display("FAIL a_unexpected_strobe: got bus 0x%0h right=%0b expected no strobe", bus_a, right_a);
      end else begin
        e = qa.pop_front();
        check("a_sample", {15'd0, right_a, bus_a}, {15'd0, e});
      end
      strobes++;
      if (left_a && lat_seen != lat_seq) begin
        check("left_latency", cyc - lat_cyc, 252);
        lat_seen = lat_seq;
      end
      if (left_a) last_left = cyc;
      if (right_a && last_left >= 0) check("left_to_right", cyc - last_left, 256);
    end

    if (left_b || right_b) begin
      if (qb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL b_unexpected_strobe: got bus 0x%0h right=%0b expected no strobe", bus_b, right_b);
      end else begin
        e = qb.pop_front();
        check("b_sample", {15'd0, right_b, bus_b}, {15'd0, e});
      end
    end

    if (act) begin
      if (sck_a && !sck_prev) begin
        if (rise_seen != rise_seq) begin
          check("first_sck_rise", cyc - rise_cyc, 4);
          rise_seen = rise_seq;
        end
        if (last_rise >= 0) check("sck_period", cyc - last_rise, 8);
        last_rise = cyc;
      end
      if (ws_a != ws_prev) check("ws_on_sck_fall", {30'd0, sck_prev, sck_a}, 32'd2);
      if (ws_a && !ws_prev) begin
        if (last_ws_rise >= 0) check("ws_period", cyc - last_ws_rise, 512);
        last_ws_rise = cyc;
      end
    end else begin
      last_rise = -1;
      last_ws_rise = -1;
      last_left = -1;
    end

    if (!act) begin
      tb_slot = 0;
    end else if (sck_prev && !sck_a) begin
      tb_slot = (tb_slot + 1) % 64;
      if (tb_slot == 31) begin
        qa.push_back({1'b0, pl_left});
        qb.push_back({1'b0, pb_left, 4'h0});
      end
      if (tb_slot == 63) begin
        qa.push_back({1'b1, pl_right});
        qb.push_back({1'b1, pb_right, 4'h0});
      end
    end
    if (act) check("ws_level", {31'd0, ws_a}, {31'd0, (tb_slot >= 32)});

    hh = tb_slot % 32;
    if (!rst_n) begin
      sd_a = ~sd_a;
      sd_b = ~sd_b;
    end else begin
      if (hh >= 1 && hh <= 16) sd_a = (tb_slot >= 32) ? pl_right[16-hh] : pl_left[16-hh];
      else sd_a = fill;
      if (hh >= 1 && hh <= 12) sd_b = (tb_slot >= 32) ? pb_right[12-hh] : pb_left[12-hh];
      else sd_b = fill;
    end

    sck_prev = sck_a;
    ws_prev = ws_a;
  end

  task automatic wait_strobes(input int target);
    int n;
    n = 0;
    while (strobes < target && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("strobe_wait", strobes, target);
  endtask

  task automatic wait_slot(input int s);
    int n;
    n = 0;
    while (tb_slot != s && n < 1200) begin
      @(negedge clk);
      n++;
    end
    check("slot_wait", tb_slot, s);
  endtask

  task automatic arm_latency();
    lat_cyc = cyc;
    lat_seq++;
  endtask

  initial begin
    rst_n = 1'b0;
    en = 1'b1;
    repeat (20) begin
      @(negedge clk);
      check("reset_hold_a", {11'd0, sck_a, ws_a, bus_a, left_a, right_a}, 32'd0);
      check("reset_hold_b", {11'd0, sck_b, ws_b, bus_b, left_b, right_b}, 32'd0);
    end

    @(posedge clk); #2;
    rst_n = 1'b1;
    rise_cyc = cyc;
    rise_seq++;
    arm_latency();
    wait_strobes(6);

    wait_slot(10);
    @(posedge clk); #2;
    en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("park_sck", {31'd0, sck_a}, 32'd0);
    check("park_ws", {31'd0, ws_a}, 32'd0);
    repeat (40) @(negedge clk);
    check("park_bus_a", {16'd0, bus_a}, 32'h1234);
    check("park_bus_b", {16'd0, bus_b}, 32'h5A50);

    pl_left = 16'h0000;
    pl_right = 16'h0000;
    fill = 1'b1;
    @(posedge clk); #2;
    en = 1'b1;
    arm_latency();
    wait_strobes(strobes + 2);

    @(posedge clk); #2;
    en = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    pl_left = 16'hA5C3;
    pl_right = 16'h1234;
    fill = 1'b0;
    en = 1'b1;
    arm_latency();
    wait_strobes(strobes + 1);
    wait_slot(40);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("async_reset_a", {11'd0, sck_a, ws_a, bus_a, left_a, right_a}, 32'd0);
    check("async_reset_b", {11'd0, sck_b, ws_b, bus_b, left_b, right_b}, 32'd0);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b1;
    arm_latency();
    wait_strobes(strobes + 2);

    @(posedge clk); #2;
    en = 1'b0;
    repeat (5) @(negedge clk);
    check("queue_a_drained", qa.size(), 0);
    check("queue_b_drained", qb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
